// File: rtl/dma_model_pkg.sv
// Shared types and helpers for the DMA memory responder model.
package dma_model_pkg;

    localparam int LINE_SHIFT = 6;
    localparam int LINE_W     = 512;
    localparam int COUNT_W    = 43;
    localparam int IDX_W_DEF  = 10;

    typedef logic [LINE_W-1:0]    line_t;
    typedef logic [COUNT_W-1:0]   count_t;
    typedef logic [IDX_W_DEF-1:0] mem_idx_t;

    typedef enum logic [1:0] {R_IDLE, R_ACTIVE, R_DONE} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_ACTIVE, W_DONE} wr_state_t;

    function automatic logic [63:0] byte_to_line(input logic [63:0] addr);
        return addr >> LINE_SHIFT;
    endfunction

endpackage

// File: rtl/dma_sync_fifo.sv
// Show-ahead synchronous FIFO with flush and occupancy count.
module dma_sync_fifo #(
    parameter int W     = 512,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  push_data,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wptr] <= push_data;
    end

endmodule

// File: rtl/dma_mem_responder.sv
// DMA-side dma_if model: read/write channels over a single-port line memory
// with read latency, FIFO credits and alternating port arbitration.
module dma_mem_responder
    import dma_model_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 64,
    parameter int SIZE_WIDTH = 43,
    parameter int MEM_LINES  = 1024,
    parameter int FIFO_DEPTH = 8,
    parameter int RD_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_go,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [SIZE_WIDTH-1:0] rd_size,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  rd_done,
    input  logic                  wr_go,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [SIZE_WIDTH-1:0] wr_size,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  wr_done
);

    localparam int IDX_W = $clog2(MEM_LINES);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;

    typedef logic [SIZE_WIDTH-1:0] cnt_t;
    typedef logic [IDX_W-1:0]      idx_t;

    rd_state_t r_state;
    wr_state_t w_state;
    idx_t      r_idx, w_idx;
    cnt_t      r_size, r_issued, r_popped;
    cnt_t      w_size, w_accepted, w_committed;
    logic [CW-1:0] inflight, r_count, w_count;
    logic [CW:0]   credit_use;
    logic [63:0]   r_line, w_line;
    logic          unused_bits;

    logic [RD_LATENCY-1:0] pipe_v;
    logic [DATA_WIDTH-1:0] pipe_d [RD_LATENCY];
    logic [DATA_WIDTH-1:0] mem [MEM_LINES];
    logic [DATA_WIDTH-1:0] w_head;
    logic w_empty;
    logic rd_req, wr_req, gnt_rd, gnt_wr, prefer_wr;
    logic rd_push, rd_pop, wr_push;

    assign r_line      = byte_to_line(64'(rd_addr));
    assign w_line      = byte_to_line(64'(wr_addr));
    assign unused_bits = ^{r_line[63:IDX_W], w_line[63:IDX_W]};

    // Reserve a FIFO slot for every line still in the latency pipe
    assign credit_use = {1'b0, inflight} + {1'b0, r_count};
    assign rd_req = (r_state == R_ACTIVE) && !rd_go
                    && (r_issued < r_size)
                    && (credit_use < (CW+1)'(FIFO_DEPTH));
    assign wr_req = (w_state == W_ACTIVE) && !wr_go && !w_empty;
    assign gnt_wr = wr_req && (!rd_req || prefer_wr);
    assign gnt_rd = rd_req && !gnt_wr;

    assign rd_push = pipe_v[RD_LATENCY-1];
    assign rd_pop  = rd_en && !empty && (r_state == R_ACTIVE)
                     && !rd_go && (r_popped < r_size);
    assign wr_push = wr_en && !full && (w_state == W_ACTIVE)
                     && !wr_go && (w_accepted < w_size);
    assign full    = (w_count == CW'(FIFO_DEPTH));

    dma_sync_fifo #(.W(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (rd_go),
        .push      (rd_push),
        .pop       (rd_pop),
        .push_data (pipe_d[RD_LATENCY-1]),
        .head      (rd_data),
        .count     (r_count),
        .empty     (empty)
    );

    dma_sync_fifo #(.W(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (wr_go),
        .push      (wr_push),
        .pop       (gnt_wr),
        .push_data (wr_data),
        .head      (w_head),
        .count     (w_count),
        .empty     (w_empty)
    );

    always_ff @(posedge clk) begin
        if (gnt_wr) mem[w_idx] <= w_head;
        pipe_d[0] <= mem[r_idx];
        for (int i = 1; i < RD_LATENCY; i++) pipe_d[i] <= pipe_d[i-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prefer_wr <= 1'b1;
        end else if (rd_req && wr_req) begin
            prefer_wr <= !prefer_wr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= R_IDLE;
            r_idx    <= '0;
            r_size   <= '0;
            r_issued <= '0;
            r_popped <= '0;
            inflight <= '0;
            pipe_v   <= '0;
            rd_done  <= 1'b0;
        end else if (rd_go) begin
            r_idx    <= r_line[IDX_W-1:0];
            r_size   <= rd_size;
            r_issued <= '0;
            r_popped <= '0;
            inflight <= '0;
            pipe_v   <= '0;
            r_state  <= (rd_size == '0) ? R_DONE : R_ACTIVE;
            rd_done  <= (rd_size == '0);
        end else begin
            pipe_v   <= (pipe_v << 1) | RD_LATENCY'(gnt_rd);
            inflight <= inflight + CW'(gnt_rd) - CW'(rd_push);
            if (gnt_rd) begin
                r_idx    <= r_idx + idx_t'(1);
                r_issued <= r_issued + cnt_t'(1);
            end
            if (rd_pop) begin
                r_popped <= r_popped + cnt_t'(1);
                if (r_popped + cnt_t'(1) == r_size) begin
                    r_state <= R_DONE;
                    rd_done <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state     <= W_IDLE;
            w_idx       <= '0;
            w_size      <= '0;
            w_accepted  <= '0;
            w_committed <= '0;
            wr_done     <= 1'b0;
        end else if (wr_go) begin
            w_idx       <= w_line[IDX_W-1:0];
            w_size      <= wr_size;
            w_accepted  <= '0;
            w_committed <= '0;
            w_state     <= (wr_size == '0) ? W_DONE : W_ACTIVE;
            wr_done     <= (wr_size == '0);
        end else begin
            if (wr_push) w_accepted <= w_accepted + cnt_t'(1);
            if (gnt_wr) begin
                w_idx       <= w_idx + idx_t'(1);
                w_committed <= w_committed + cnt_t'(1);
                if (w_committed + cnt_t'(1) == w_size) begin
                    w_state <= W_DONE;
                    wr_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dma_mem_responder.sv
// Directed bench for dma_mem_responder: table of write/readback transfers
// plus hand-written sequences for back-pressure, contention, wrap and reset.
module tb_dma_mem_responder;

    logic         clk;
    logic         rst_n;
    logic         rd_go;
    logic [63:0]  rd_addr;
    logic [42:0]  rd_size;
    logic         rd_en;
    logic [511:0] rd_data;
    logic         empty;
    logic         rd_done;
    logic         wr_go;
    logic [63:0]  wr_addr;
    logic [42:0]  wr_size;
    logic         wr_en;
    logic [511:0] wr_data;
    logic         full;
    logic         wr_done;

    int tests = 0;
    int fails = 0;

    logic mon_on    = 1'b0;
    logic full_seen = 1'b0;
    logic exp_pref  = 1'b1;
    int   contested = 0;
    int   alt_err   = 0;

    typedef struct {
        logic [63:0] addr;
        int          size;
        logic [7:0]  tag;
        int          lat;
    } vec_t;

    vec_t vecs [4];

    dma_mem_responder dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_go   (rd_go),
        .rd_addr (rd_addr),
        .rd_size (rd_size),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (empty),
        .rd_done (rd_done),
        .wr_go   (wr_go),
        .wr_addr (wr_addr),
        .wr_size (wr_size),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .wr_done (wr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_on) begin
            if (full) full_seen = 1'b1;
            if (dut.rd_req && dut.wr_req) begin
                contested++;
                if (dut.gnt_wr !== exp_pref) alt_err++;
                exp_pref = !exp_pref;
            end
        end
    end

    function automatic logic [511:0] pat(input logic [7:0] tag, input int i);
        logic [7:0] b;
        b = tag + 8'(i);
        return {64{b}};
    endfunction

    task automatic check_val(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_line(input string name, input logic [511:0] act,
                              input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_read(input logic [63:0] a, input int n);
        rd_addr = a;
        rd_size = 43'(n);
        rd_go   = 1'b1;
        tick();
        rd_go   = 1'b0;
    endtask

    task automatic start_write(input logic [63:0] a, input int n);
        wr_addr = a;
        wr_size = 43'(n);
        wr_go   = 1'b1;
        tick();
        wr_go   = 1'b0;
    endtask

    task automatic write_lines(input logic [7:0] tag, input int n);
        int g;
        for (int i = 0; i < n; i++) begin
            wr_data = pat(tag, i);
            wr_en   = 1'b1;
            g = 0;
            while (full && g < 100) begin
                tick();
                g++;
            end
            if (g >= 100) check_val("wr_accept_timeout", 32'(full), 0);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic read_lines(input logic [7:0] tag, input int n);
        int g;
        for (int i = 0; i < n; i++) begin
            g = 0;
            while (empty && g < 200) begin
                tick();
                g++;
            end
            if (g >= 200) check_val("rd_data_timeout", 32'(empty), 0);
            check_line("rd_data", rd_data, pat(tag, i));
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
        end
    endtask

    task automatic wait_wr_done(input int lim);
        int g;
        g = 0;
        while (!wr_done && g < lim) begin
            tick();
            g++;
        end
        check_val("wr_done", 32'(wr_done), 1);
    endtask

    initial begin
        int g;
        vecs[0] = '{64'h1000, 4,  8'hA0, 5};
        vecs[1] = '{64'h4B00, 16, 8'h40, 5};
        vecs[2] = '{64'h8000, 20, 8'h10, 5};
        vecs[3] = '{64'h2000, 1,  8'h55, 5};

        rst_n   = 1'b0;
        rd_go   = 1'b0;
        rd_addr = '0;
        rd_size = '0;
        rd_en   = 1'b0;
        wr_go   = 1'b0;
        wr_addr = '0;
        wr_size = '0;
        wr_en   = 1'b0;
        wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_empty", 32'(empty), 1);
        check_val("rst_full", 32'(full), 0);
        check_val("rst_rd_done", 32'(rd_done), 0);
        check_val("rst_wr_done", 32'(wr_done), 0);
        check_line("rst_rd_data", rd_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Write then read back each region; first data lands 5 edges after go
        for (int k = 0; k < 4; k++) begin
            start_write(vecs[k].addr, vecs[k].size);
            check_val("wr_done_low", 32'(wr_done), 0);
            write_lines(vecs[k].tag, vecs[k].size);
            wait_wr_done(100);
            start_read(vecs[k].addr, vecs[k].size);
            check_val("rd_done_low", 32'(rd_done), 0);
            g = 0;
            while (empty && g < 50) begin
                tick();
                g++;
            end
            check_val("first_data_lat", g, vecs[k].lat);
            read_lines(vecs[k].tag, vecs[k].size);
            repeat (3) tick();
            check_val("rd_done_held", 32'(rd_done), 1);
            check_val("wr_done_held", 32'(wr_done), 1);
            check_val("empty_after_rd", 32'(empty), 1);
        end

        // Consumer stalled: FIFO fills to its depth and requests stop
        start_read(64'h8000, 20);
        repeat (30) tick();
        check_val("stall_fifo_count", 32'(dut.r_count), 8);
        check_val("stall_inflight", 32'(dut.inflight), 0);
        check_val("stall_rd_done", 32'(rd_done), 0);
        read_lines(8'h10, 20);
        check_val("stall_rd_done_end", 32'(rd_done), 1);

        // Concurrent read and write on disjoint regions
        rd_addr = 64'h4B00;
        rd_size = 43'd16;
        wr_addr = 64'h9600;
        wr_size = 43'd16;
        rd_go   = 1'b1;
        wr_go   = 1'b1;
        mon_on  = 1'b1;
        tick();
        rd_go   = 1'b0;
        wr_go   = 1'b0;
        fork
            write_lines(8'h70, 16);
            read_lines(8'h40, 16);
        join
        wait_wr_done(100);
        mon_on = 1'b0;
        check_val("conc_rd_done", 32'(rd_done), 1);
        check_val("conc_full_seen", 32'(full_seen), 1);
        check_val("conc_contested", 32'(contested > 4), 1);
        check_val("conc_alternate", alt_err, 0);
        start_read(64'h9600, 16);
        read_lines(8'h70, 16);
        check_val("conc_readback_done", 32'(rd_done), 1);

        // Index wraps from the last line to line 0
        start_write(64'hFFC0, 2);
        write_lines(8'hC0, 2);
        wait_wr_done(100);
        start_read(64'h0, 1);
        read_lines(8'hC1, 1);
        start_read(64'hFFC0, 2);
        read_lines(8'hC0, 2);
        check_val("wrap_rd_done", 32'(rd_done), 1);

        // Zero-size go restarts both channels straight into done
        rd_addr = 64'h1000;
        rd_size = 43'd4;
        wr_addr = 64'h3000;
        wr_size = 43'd2;
        rd_go   = 1'b1;
        wr_go   = 1'b1;
        tick();
        check_val("nz_rd_done", 32'(rd_done), 0);
        check_val("nz_wr_done", 32'(wr_done), 0);
        rd_size = '0;
        wr_size = '0;
        tick();
        rd_go   = 1'b0;
        wr_go   = 1'b0;
        check_val("zero_rd_done", 32'(rd_done), 1);
        check_val("zero_wr_done", 32'(wr_done), 1);
        repeat (8) tick();
        check_val("zero_empty", 32'(empty), 1);
        check_val("zero_inflight", 32'(dut.inflight), 0);
        check_val("zero_done_held", 32'({rd_done, wr_done}), 3);

        // Reset in the middle of a write and a read
        start_write(64'h1900, 8);
        write_lines(8'hE0, 3);
        repeat (4) tick();
        start_read(64'h4B00, 8);
        g = 0;
        while (empty && g < 50) begin
            tick();
            g++;
        end
        check_val("pre_rst_nonempty", 32'(empty), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_empty", 32'(empty), 1);
        check_val("mid_rst_full", 32'(full), 0);
        check_val("mid_rst_rd_done", 32'(rd_done), 0);
        check_val("mid_rst_wr_done", 32'(wr_done), 0);
        check_line("mid_rst_rd_data", rd_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        start_write(64'h19C0, 5);
        write_lines(8'hE3, 5);
        wait_wr_done(100);
        start_read(64'h1900, 8);
        read_lines(8'hE0, 8);
        check_val("post_rst_rd_done", 32'(rd_done), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
